// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the batch run sequencer.
// The optional watchdog is enabled by defining RUN_SEQ_WATCHDOG_EN.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        REQ,
        RUN,
        NEXT,
        FIN
    } run_state_t;

    localparam int DEF_NUM_PROGS   = 3;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_RESET_CYC   = 4;
    localparam int DEF_TIMEOUT_CYC = 4096;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on demand and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/run_sequencer.sv
// Runs a batch of programs on the core: reset, one-cycle req, wait for done, report cycles.
// Define RUN_SEQ_WATCHDOG_EN to abort a program that runs TIMEOUT_CYC cycles without done.
//
//   state | meaning
//   IDLE  | core held in reset, waiting for start
//   RST   | core reset asserted for RESET_CYC cycles, cycle counter cleared
//   REQ   | one-cycle request to the core, counter starts at 1
//   RUN   | counting cycles until core_done (or watchdog)
//   NEXT  | publish result, advance to next program or finish
//   FIN   | batch complete, core released from reset for inspection
module run_sequencer import run_seq_pkg::*; #(
    parameter int NUM_PROGS   = DEF_NUM_PROGS,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RESET_CYC   = DEF_RESET_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int IDX_W       = idx_width(NUM_PROGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             core_reset,
    output logic             core_req,
    input  logic             core_done,
    output logic [IDX_W-1:0] prog_idx,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             cyc_valid,
    output logic [IDX_W-1:0] cyc_prog,
    output logic [CNT_W-1:0] cyc_count
);

    localparam int HOLD_W = idx_width(RESET_CYC);
    localparam logic [IDX_W-1:0]  LAST_PROG = IDX_W'(NUM_PROGS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYC - 1);

    run_state_t       r_state;
    logic             r_core_reset;
    logic             r_core_req;
    logic [IDX_W-1:0] r_prog_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;
    logic             r_cyc_valid;
    logic [IDX_W-1:0] r_cyc_prog;
    logic [CNT_W-1:0] r_cyc_count;

    logic [CNT_W-1:0]  w_cnt_q;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic [HOLD_W-1:0] w_hold_q;
    logic              w_hold_clr;
    logic              w_hold_inc;
    logic              w_hold_last;
    logic              w_wd_hit;

`ifdef RUN_SEQ_WATCHDOG_EN
    assign w_wd_hit = (r_state == RUN) && !core_done && (w_cnt_q >= CNT_W'(TIMEOUT_CYC));
`else
    assign w_wd_hit = 1'b0;
`endif

    // The cycle counter holds on the cycle that ends RUN so NEXT can report it.
    assign w_cnt_clr = (r_state == RST);
    assign w_cnt_inc = (r_state == REQ) || ((r_state == RUN) && !core_done && !w_wd_hit);

    assign w_hold_clr  = (r_state != RST);
    assign w_hold_inc  = (r_state == RST);
    assign w_hold_last = (w_hold_q == HOLD_LAST);

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .q     (w_cnt_q)
    );

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (w_hold_clr),
        .inc   (w_hold_inc),
        .q     (w_hold_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_core_reset <= 1'b1;
            r_core_req   <= 1'b0;
            r_prog_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_cyc_valid  <= 1'b0;
            r_cyc_prog   <= '0;
            r_cyc_count  <= '0;
        end else begin
            r_core_req  <= 1'b0;
            r_cyc_valid <= 1'b0;
            case (r_state)
                IDLE, FIN: begin
                    if (start) begin
                        r_state      <= RST;
                        r_prog_idx   <= '0;
                        r_done       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_core_reset <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                RST: begin
                    if (w_hold_last) begin
                        r_state      <= REQ;
                        r_core_reset <= 1'b0;
                        r_core_req   <= 1'b1;
                    end
                end
                REQ: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (core_done || w_wd_hit) begin
                        r_state     <= NEXT;
                        r_cyc_valid <= 1'b1;
                        r_cyc_prog  <= r_prog_idx;
                        r_cyc_count <= w_cnt_q;
                        if (w_wd_hit) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
                NEXT: begin
                    if (r_prog_idx == LAST_PROG) begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state      <= RST;
                        r_prog_idx   <= r_prog_idx + IDX_W'(1);
                        r_core_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign core_reset = r_core_reset;
    assign core_req   = r_core_req;
    assign prog_idx   = r_prog_idx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign timeout    = r_timeout;
    assign cyc_valid  = r_cyc_valid;
    assign cyc_prog   = r_cyc_prog;
    assign cyc_count  = r_cyc_count;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: a schedule model predicts every output each cycle from the
// per-program core latencies; directed and random batches drive it.
module tb_run_sequencer;

    localparam int NP    = 3;
    localparam int CW    = 8;
    localparam int RC    = 4;
    localparam int TO    = 20;
    localparam int IW    = 2;
    localparam int NEVER = 50000;
    localparam int SAT   = (1 << CW) - 1;
`ifdef RUN_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          core_done = 1'b0;
    logic          core_reset, core_req, busy, done, timeout, cyc_valid;
    logic [IW-1:0] prog_idx, cyc_prog;
    logic [CW-1:0] cyc_count;

    run_sequencer #(
        .NUM_PROGS   (NP),
        .CNT_W       (CW),
        .RESET_CYC   (RC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_reset (core_reset),
        .core_req   (core_req),
        .core_done  (core_done),
        .prog_idx   (prog_idx),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cyc_valid  (cyc_valid),
        .cyc_prog   (cyc_prog),
        .cyc_count  (cyc_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Core model: done rises lat+1 cycles after the req cycle; cleared by core_reset.
    int lat[NP];
    bit always_done = 1'b0;
    int core_n = 0;
    bit armed = 1'b0;
    int req_t = 0;
    int cur_lat = 0;

    always @(posedge clk) begin
        #1;
        if (always_done) begin
            armed = 1'b0;
            core_done = 1'b1;
        end else if (core_reset) begin
            armed = 1'b0;
            core_done = 1'b0;
        end else if (core_req) begin
            armed = 1'b1;
            req_t = cyc;
            cur_lat = lat[(core_n < NP) ? core_n : NP - 1];
            core_n++;
            core_done = 1'b0;
        end else begin
            core_done = armed && (cyc >= req_t + cur_lat + 1);
        end
    end

    // Schedule model: per program, RST start, REQ cycle, last RUN cycle, result.
    bit m_active = 1'b0;
    int m_s[NP], m_q[NP], m_d[NP], m_cnt[NP];
    bit m_to[NP];
    int exp_cprog = 0;
    int exp_ccnt = 0;
    bit e_rst, e_req, e_busy, e_done, e_to, e_val;
    int e_prog;
    int rq_prog[$], rq_cnt[$], req_q[$];

    always @(negedge clk) begin
        int c;
        int t;
        c = cyc;
        e_rst = 1'b1; e_req = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_to = 1'b0; e_val = 1'b0;
        e_prog = 0;
        if (m_active) begin
            e_rst = 1'b0;
            e_prog = NP - 1;
            e_done = 1'b1;
            if (c <= m_d[NP-1] + 1) begin
                e_done = 1'b0;
                e_busy = 1'b1;
                for (int p = 0; p < NP; p++) begin
                    if (c >= m_s[p] && c <= m_d[p] + 1) begin
                        e_prog = p;
                        e_rst  = (c < m_q[p]);
                        e_req  = (c == m_q[p]);
                        if (c == m_d[p] + 1) begin
                            e_val = 1'b1;
                            exp_cprog = p;
                            exp_ccnt = m_cnt[p];
                        end
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (m_to[p] && c >= m_d[p] + 1) e_to = 1'b1;
            end
        end
        chk("core_reset", core_reset, e_rst);
        chk("core_req", core_req, e_req);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("timeout", timeout, e_to);
        chk("cyc_valid", cyc_valid, e_val);
        chk("prog_idx", prog_idx, e_prog);
        chk("cyc_prog", cyc_prog, exp_cprog);
        chk("cyc_count", cyc_count, exp_ccnt);
        if (cyc_valid) begin
            rq_prog.push_back(int'(cyc_prog));
            rq_cnt.push_back(int'(cyc_count));
        end
        if (core_req) req_q.push_back(c);
        // Inputs seen now are what the next rising edge samples.
        if (reset) begin
            m_active = 1'b0;
            exp_cprog = 0;
            exp_ccnt = 0;
        end else if (start && !e_busy) begin
            t = c + 1;
            for (int p = 0; p < NP; p++) begin
                m_s[p] = t;
                m_q[p] = t + RC;
                if (WD && (lat[p] + 1 > TO)) begin
                    m_d[p] = m_q[p] + TO;
                    m_cnt[p] = TO;
                    m_to[p] = 1'b1;
                end else begin
                    m_d[p] = m_q[p] + lat[p] + 1;
                    m_cnt[p] = (lat[p] + 1 > SAT) ? SAT : lat[p] + 1;
                    m_to[p] = 1'b0;
                end
                t = m_d[p] + 2;
            end
            m_active = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(posedge clk);
        #2;
    endtask

    task automatic do_start();
        core_n = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic set_lat(input int a, input int b, input int c);
        lat[0] = a; lat[1] = b; lat[2] = c;
        rq_prog.delete(); rq_cnt.delete(); req_q.delete();
    endtask

    task automatic run_batch(input int a, input int b, input int c);
        set_lat(a, b, c);
        do_start();
        wait_until(m_d[NP-1] + 4);
    endtask

    task automatic check_res(input string tag, input int n, input int c0, input int c1, input int c2);
        int ec[3];
        ec[0] = c0; ec[1] = c1; ec[2] = c2;
        chk($sformatf("%s result count", tag), rq_cnt.size(), n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s prog%0d id", tag, i), (i < rq_prog.size()) ? rq_prog[i] : -1, i);
            chk($sformatf("%s prog%0d cycles", tag, i), (i < rq_cnt.size()) ? rq_cnt[i] : -1, ec[i]);
        end
    endtask

    initial begin
        #(10 * 30000);
        $display("FAIL global_timeout: got no end of run, expected end within 30000 cycles");
        $fatal(1, "bench stopped");
    end

    initial begin
        int rst_at;
        for (int i = 0; i < NP; i++) lat[i] = 0;
        repeat (3) step();
        reset = 1'b0;
        chk("reset core_reset", core_reset, 1);
        chk("reset busy", busy, 0);
        chk("reset cyc_count", cyc_count, 0);

        // Nominal batch
        run_batch(5, 7, 2);
        check_res("nominal", 3, 6, 8, 3);
        chk("nominal fin done", done, 1);
        chk("nominal fin busy", busy, 0);
        chk("nominal fin timeout", timeout, 0);
        chk("nominal fin core_reset", core_reset, 0);

        // Restart from FIN, with start pulses while busy
        set_lat(5, 7, 2);
        do_start();
        chk("restart done cleared", done, 0);
        chk("restart busy", busy, 1);
        repeat (6) step();
        pulse_start();
        repeat (12) step();
        pulse_start();
        wait_until(m_d[NP-1] + 4);
        check_res("restart", 3, 6, 8, 3);

        // Core done held high throughout
        always_done = 1'b1;
        run_batch(0, 0, 0);
        check_res("immediate", 3, 1, 1, 1);
        chk("immediate req pulses", req_q.size(), 3);
        chk("immediate gap 0-1", (req_q.size() > 1) ? req_q[1] - req_q[0] - 2 : -1, 5);
        chk("immediate gap 1-2", (req_q.size() > 2) ? req_q[2] - req_q[1] - 2 : -1, 5);
        always_done = 1'b0;

        // Mid-run reset during program 1
        set_lat(5, 10, 2);
        do_start();
        wait_until(m_q[1] + 3);
        do_reset(1);
        chk("midreset busy", busy, 0);
        chk("midreset core_reset", core_reset, 1);
        chk("midreset prog_idx", prog_idx, 0);
        check_res("midreset partial", 1, 6, 0, 0);
        run_batch(5, 7, 2);
        check_res("after midreset", 3, 6, 8, 3);

        // Program 1 never completes
        set_lat(3, NEVER, 4);
        do_start();
        if (WD) begin
            wait_until(m_d[NP-1] + 4);
            check_res("watchdog", 3, 4, 20, 5);
            chk("watchdog timeout", timeout, 1);
            chk("watchdog done", done, 1);
        end else begin
            wait_until(m_q[1] + 60);
            chk("hang busy", busy, 1);
            check_res("hang", 1, 4, 0, 0);
            do_reset(2);
        end

        // Counter saturation
        if (!WD) begin
            run_batch(300, 1, 1);
            check_res("saturation", 3, SAT, 2, 2);
        end

        // Random batches with stray starts and occasional resets
        for (int it = 0; it < 14; it++) begin
            set_lat($urandom_range(0, 30), $urandom_range(0, 30), $urandom_range(0, 30));
            do_start();
            rst_at = ($urandom_range(0, 3) == 0) ? m_s[0] + $urandom_range(0, m_d[NP-1] - m_s[0]) : -1;
            while (cyc < m_d[NP-1] + 4) begin
                if (cyc == rst_at) begin
                    do_reset(1);
                    break;
                end
                if ($urandom_range(0, 15) == 0 && cyc + 2 < m_d[NP-1]) pulse_start();
                else step();
            end
        end

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
